// File: rtl/lynx_pkg.sv
// rtl/lynx_pkg.sv - shared types, constants and address fold for the Lynx RAM loader arbiter
package lynx_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, JUMP} state_e;

  localparam logic [15:0] LOW_LIMIT_DEF = 16'h6000;
  localparam int          AW_DEF        = 14;

  // 48K mode keeps A14 as the bank bit and skips A13.
  function automatic logic [13:0] fold_addr(input logic [15:0] a, input logic mode48);
    return mode48 ? {a[14], a[12:0]} : a[13:0];
  endfunction

endpackage

// File: rtl/lynx_skid2.sv
// rtl/lynx_skid2.sv - two-entry FIFO holding {addr, data} loader pairs
module lynx_skid2 (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  logic [23:0] push_data_i,
  input  logic        pop_i,
  output logic [23:0] head_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [23:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lynx_ram_loader_arb.sv
// rtl/lynx_ram_loader_arb.sv - shares main RAM between the Z80 and the cassette/ioctl loader
module lynx_ram_loader_arb import lynx_pkg::*; #(
  parameter int          AW        = AW_DEF,
  parameter logic [15:0] LOW_LIMIT = LOW_LIMIT_DEF,
  parameter int          JUMP_HOLD = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cep,
  input  logic          mode48,
  input  logic [15:0]   cpu_a,
  input  logic          cpu_ramsel,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_di,
  output logic [7:0]    cpu_do,
  output logic          cpu_hold,
  input  logic          ld_valid,
  input  logic [15:0]   ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  input  logic [15:0]   ld_entry,
  output logic [AW-1:0] ram_a,
  output logic          ram_we,
  output logic [7:0]    ram_di,
  input  logic [7:0]    ram_do,
  output logic [15:0]   dir,
  output logic          dirset,
  output logic [7:0]    drop_cnt,
  output logic          busy
);

  state_e      state_q;
  logic        cpu_hold_q, dirset_q, rd_pend_q;
  logic [15:0] dir_q;
  logic [7:0]  drop_cnt_q, cpu_do_q, jcnt_q;
  logic [23:0] head;
  logic        full, empty;
  logic        cpu_slot, accept, drop, push, pop;
  logic [13:0] ram_a_fold;

  assign cpu_slot = cep && !cpu_hold_q && cpu_ramsel;
  assign ld_ready = ((state_q == IDLE) || (state_q == LOAD)) && !full;
  assign accept   = ld_valid && ld_ready;
  assign drop     = accept && (ld_addr < LOW_LIMIT);
  assign push     = accept && !drop;
  assign pop      = !reset && !cpu_slot && !empty;

  lynx_skid2 u_skid (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({ld_addr, ld_data}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Any slot the CPU does not claim is a loader slot.
  assign ram_a_fold = cpu_slot ? fold_addr(cpu_a, mode48) : fold_addr(head[23:8], mode48);
  assign ram_a      = AW'(ram_a_fold);
  assign ram_we     = !reset && (cpu_slot ? cpu_we : !empty);
  assign ram_di     = cpu_slot ? cpu_di : head[7:0];

  assign cpu_do   = cpu_do_q;
  assign cpu_hold = cpu_hold_q;
  assign dirset   = dirset_q;
  assign dir      = dir_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      cpu_do_q   <= 8'h00;
      drop_cnt_q <= 8'h00;
    end else begin
      rd_pend_q <= cpu_slot && !cpu_we;
      if (rd_pend_q) cpu_do_q <= ram_do;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cpu_hold_q <= 1'b0;
      dirset_q   <= 1'b0;
      dir_q      <= 16'h0000;
      jcnt_q     <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_done) begin
            dir_q <= ld_entry;
            if (accept || !empty) begin
              state_q    <= DRAIN;
              cpu_hold_q <= 1'b1;
            end else begin
              state_q  <= JUMP;
              dirset_q <= 1'b1;
              jcnt_q   <= 8'd0;
            end
          end else if (accept) begin
            state_q    <= LOAD;
            cpu_hold_q <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_done) begin
            state_q <= DRAIN;
            dir_q   <= ld_entry;
          end
        end
        DRAIN: begin
          if (empty) begin
            state_q    <= JUMP;
            cpu_hold_q <= 1'b0;
            dirset_q   <= 1'b1;
            jcnt_q     <= 8'd0;
          end
        end
        JUMP: begin
          if (cep) begin
            if (jcnt_q == 8'(JUMP_HOLD - 1)) begin
              state_q  <= IDLE;
              dirset_q <= 1'b0;
            end else begin
              jcnt_q <= jcnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
